// File: rtl/graph_bfs_path.sv
// BFS shortest-path engine: capture, wavefront expansion, parent trace, path stream.
// Optional GRAPH_UNDIRECTED_EN symmetrises the captured adjacency.
module graph_bfs_path #(
  parameter int NODE_NUM = 32,
  parameter int IDX_W    = 5
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic [NODE_NUM*NODE_NUM-1:0] edgeMask,
  input  logic                         startReq,
  input  logic [IDX_W-1:0]             startPoint,
  input  logic [IDX_W-1:0]             endpoint,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [IDX_W:0]               hopCount,
  output logic                         pathValid,
  input  logic                         pathReady,
  output logic [IDX_W-1:0]             pathNode,
  output logic                         pathLast
);

  localparam int NN = NODE_NUM * NODE_NUM;

  typedef enum logic [2:0] {
    IDLE, INIT, FORWARD, BACKWARD, PUTOUT, FIN
  } state_t;

  state_t state, state_n;

  logic [NN-1:0]       adj, adj_in;
  logic [IDX_W-1:0]    sp, ep, level, cur, ptr, optr;
  logic [NODE_NUM-1:0] visited, frontier, nxt, start_oh, end_oh;
  logic [IDX_W-1:0]    parent [NODE_NUM];
  logic [IDX_W-1:0]    par_n  [NODE_NUM];
  logic [IDX_W-1:0]    pbuf   [NODE_NUM];
  logic                range_ok, hit, last_beat;

`ifdef GRAPH_UNDIRECTED_EN
  always_comb begin
    adj_in = '0;
    for (int i = 0; i < NODE_NUM; i++)
      for (int j = 0; j < NODE_NUM; j++)
        adj_in[i*NODE_NUM+j] = edgeMask[i*NODE_NUM+j]
                             | edgeMask[j*NODE_NUM+i];
  end
`else
  always_comb adj_in = edgeMask;
`endif

  always_comb begin
    start_oh = '0;
    end_oh   = '0;
    for (int j = 0; j < NODE_NUM; j++) begin
      start_oh[j] = (IDX_W'(j) == sp);
      end_oh[j]   = (IDX_W'(j) == ep);
    end
  end

  assign range_ok = ({1'b0, sp} < (IDX_W+1)'(NODE_NUM))
                 && ({1'b0, ep} < (IDX_W+1)'(NODE_NUM));

  // descending scan so the lowest-index frontier parent wins
  always_comb begin
    nxt = '0;
    for (int j = 0; j < NODE_NUM; j++) begin
      par_n[j] = parent[j];
      for (int i = NODE_NUM - 1; i >= 0; i--) begin
        if (frontier[i] && adj[i*NODE_NUM+j] && !visited[j]) begin
          nxt[j]   = 1'b1;
          par_n[j] = IDX_W'(i);
        end
      end
    end
  end

  assign hit       = |(nxt & end_oh);
  assign last_beat = (optr == level);

  always_ff @(posedge CLK) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (startReq) state_n = INIT;
      INIT: begin
        if (!range_ok)     state_n = FIN;
        else if (sp == ep) state_n = BACKWARD;
        else               state_n = FORWARD;
      end
      FORWARD: begin
        if (hit)           state_n = BACKWARD;
        else if (nxt == '0) state_n = FIN;
      end
      BACKWARD: if (ptr == '0) state_n = PUTOUT;
      PUTOUT:   if (pathReady && last_beat) state_n = FIN;
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign busy      = (state == INIT) || (state == FORWARD)
                  || (state == BACKWARD) || (state == PUTOUT);
  assign done      = (state == FIN);
  assign pathValid = (state == PUTOUT);
  assign pathNode  = pathValid ? pbuf[optr] : '0;
  assign pathLast  = pathValid && last_beat;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      adj      <= '0;
      sp       <= '0;
      ep       <= '0;
      level    <= '0;
      cur      <= '0;
      ptr      <= '0;
      optr     <= '0;
      visited  <= '0;
      frontier <= '0;
      found    <= 1'b0;
      hopCount <= '0;
      for (int j = 0; j < NODE_NUM; j++) begin
        parent[j] <= '0;
        pbuf[j]   <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (startReq) begin
            adj      <= adj_in;
            sp       <= startPoint;
            ep       <= endpoint;
            found    <= 1'b0;
            hopCount <= '0;
          end
        end
        INIT: begin
          visited  <= start_oh;
          frontier <= start_oh;
          level    <= '0;
          cur      <= ep;
          ptr      <= '0;
        end
        FORWARD: begin
          visited  <= visited | nxt;
          frontier <= nxt;
          level    <= level + 1'b1;
          ptr      <= level + 1'b1;
          cur      <= ep;
          for (int j = 0; j < NODE_NUM; j++) parent[j] <= par_n[j];
        end
        BACKWARD: begin
          pbuf[ptr] <= cur;
          cur       <= parent[cur];
          if (ptr == '0) begin
            found    <= 1'b1;
            hopCount <= {1'b0, level};
            optr     <= '0;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end
        PUTOUT: if (pathReady && !last_beat) optr <= optr + 1'b1;
        FIN: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_graph_bfs_path.sv
// Directed-vector bench for graph_bfs_path: path, latency, stall and reset cases.
module tb_graph_bfs_path;

  localparam int N  = 32;
  localparam int W  = 5;
  localparam int NN = N * N;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [NN-1:0] edgeMask = '0;
  logic          startReq = 1'b0;
  logic [W-1:0]  startPoint = '0;
  logic [W-1:0]  endpoint = '0;
  logic          busy, done, found;
  logic [W:0]    hopCount;
  logic          pathValid;
  logic          pathReady = 1'b0;
  logic [W-1:0]  pathNode;
  logic          pathLast;

  graph_bfs_path #(.NODE_NUM(N), .IDX_W(W)) dut (
    .CLK(CLK), .RST_n(RST_n), .edgeMask(edgeMask),
    .startReq(startReq), .startPoint(startPoint), .endpoint(endpoint),
    .busy(busy), .done(done), .found(found), .hopCount(hopCount),
    .pathValid(pathValid), .pathReady(pathReady),
    .pathNode(pathNode), .pathLast(pathLast)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [NN-1:0] add(input logic [NN-1:0] m,
                                        input int i, input int j);
    m[i*N+j] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0][7:0] mkp(input int a0, input int a1,
                                           input int a2, input int a3,
                                           input int a4, input int a5);
    logic [15:0][7:0] p;
    p = '0;
    p[0] = 8'(a0); p[1] = 8'(a1); p[2] = 8'(a2);
    p[3] = 8'(a3); p[4] = 8'(a4); p[5] = 8'(a5);
    return p;
  endfunction

  typedef struct {
    logic [NN-1:0]    mask;
    int               s;
    int               e;
    int               mode;
    int               xfound;
    int               xhop;
    int               xlen;
    logic [15:0][7:0] xpath;
    int               xdone;
  } vec_t;

  vec_t vt [7];

  task automatic run_vec(input int k);
    vec_t v;
    int cyc, nb, dc, pn;
    bit pv, pr, injected;
    v = vt[k];
    @(negedge CLK);
    edgeMask   = v.mask;
    startPoint = W'(v.s);
    endpoint   = W'(v.e);
    startReq   = 1'b1;
    @(negedge CLK);
    startReq   = 1'b0;
    edgeMask   = ~v.mask;
    startPoint = ~startPoint;
    endpoint   = ~endpoint;
    #1;
    chk($sformatf("v%0d_busy_init", k), int'(busy), 1);
    chk($sformatf("v%0d_found_clr", k), int'(found), 0);
    chk($sformatf("v%0d_hop_clr", k), int'(hopCount), 0);
    cyc = 0; nb = 0; dc = -1; pn = 0;
    pv = 1'b0; pr = 1'b0; injected = 1'b0;
    while (cyc < 300) begin
      startReq  = 1'b0;
      pathReady = (v.mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (pv && !pr) begin
        chk($sformatf("v%0d_hold_valid", k), int'(pathValid), 1);
        chk($sformatf("v%0d_hold_node", k), int'(pathNode), pn);
      end
      if (pathValid && pathReady) begin
        chk($sformatf("v%0d_node%0d", k, nb), int'(pathNode),
            (nb < v.xlen) ? int'(v.xpath[nb]) : -1);
        chk($sformatf("v%0d_last%0d", k, nb), int'(pathLast),
            int'(nb == v.xlen - 1));
        nb++;
      end
      if (v.mode == 1 && pathValid && !injected) begin
        startReq   = 1'b1;
        startPoint = 5'd3;
        endpoint   = 5'd9;
        injected   = 1'b1;
      end
      pv = pathValid;
      pr = pathReady;
      pn = int'(pathNode);
      if (done) begin
        dc = cyc;
        break;
      end
      cyc++;
      @(negedge CLK);
    end
    startReq = 1'b0;
    chk($sformatf("v%0d_done_seen", k), int'(dc >= 0), 1);
    if (v.xdone >= 0)
      chk($sformatf("v%0d_done_cycle", k), dc, v.xdone);
    chk($sformatf("v%0d_busy_fin", k), int'(busy), 0);
    chk($sformatf("v%0d_found", k), int'(found), v.xfound);
    chk($sformatf("v%0d_hop", k), int'(hopCount), v.xhop);
    chk($sformatf("v%0d_beats", k), nb, v.xlen);
    @(negedge CLK);
    #1;
    chk($sformatf("v%0d_done_pulse", k), int'(done), 0);
    chk($sformatf("v%0d_found_held", k), int'(found), v.xfound);
  endtask

  logic [NN-1:0] m;
  int seen;

  initial begin
    vt[0] = '{add(add(add('0, 0, 1), 1, 2), 2, 3), 0, 3, 0,
              1, 3, 4, mkp(0, 1, 2, 3, 0, 0), 12};
    vt[1] = '{add(add(add(add('0, 0, 4), 0, 2), 2, 7), 4, 7), 0, 7, 0,
              1, 2, 3, mkp(0, 2, 7, 0, 0, 0), 9};
    vt[2] = '{'0, 5, 5, 0, 1, 0, 1, mkp(5, 0, 0, 0, 0, 0), 3};
`ifdef GRAPH_UNDIRECTED_EN
    vt[3] = '{add('0, 3, 1), 1, 3, 0, 1, 1, 2, mkp(1, 3, 0, 0, 0, 0), 6};
`else
    vt[3] = '{add('0, 3, 1), 1, 3, 0, 0, 0, 0, mkp(0, 0, 0, 0, 0, 0), 2};
`endif
    m = '0;
    for (int i = 0; i < 5; i++) m = add(m, i, i + 1);
    vt[4] = '{m, 0, 5, 1, 1, 5, 6, mkp(0, 1, 2, 3, 4, 5), -1};
    vt[5] = '{add(add(add('0, 0, 0), 0, 1), 1, 2), 0, 9, 0,
              0, 0, 0, mkp(0, 0, 0, 0, 0, 0), 4};
    vt[6] = '{add('0, 31, 0), 31, 0, 0, 1, 1, 2, mkp(31, 0, 0, 0, 0, 0), 6};

    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(pathValid), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_hop", int'(hopCount), 0);
    RST_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    m = '0;
    for (int i = 0; i < 20; i++) m = add(m, i, i + 1);
    @(negedge CLK);
    edgeMask   = m;
    startPoint = 5'd0;
    endpoint   = 5'd20;
    startReq   = 1'b1;
    @(negedge CLK);
    startReq = 1'b0;
    repeat (4) @(negedge CLK);
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(pathValid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_found", int'(found), 0);
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      #1;
      if (done || busy) seen++;
    end
    chk("mid_rst_no_activity", seen, 0);

    run_vec(0);
    run_vec(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
